// File: rtl/apb_ucpd_frs_tx_if.sv
// Control/status bundle between the UCPD FRS register block (master) and the FRS transmitter (slave).
// cc_sense is only consumed when the transmitter is built with UCPD_FRS_CHK_EN.
interface apb_ucpd_frs_tx_if #(
    parameter int US_W   = 10,
    parameter int FREQ_W = 6
);
    logic [FREQ_W-1:0] clk_freq;
    logic              frs_en;
    logic              frs_tx_req;
    logic [US_W-1:0]   pulse_us;
    logic [US_W-1:0]   guard_us;
    logic              cc_sense;
    logic              frs_tx_out;
    logic              frs_busy;
    logic              frs_done;
    logic              frs_rej;
    logic              frs_abort;
    logic              frs_err;

    modport master (
        output clk_freq, frs_en, frs_tx_req, pulse_us, guard_us, cc_sense,
        input  frs_tx_out, frs_busy, frs_done, frs_rej, frs_abort, frs_err
    );

    modport slave (
        input  clk_freq, frs_en, frs_tx_req, pulse_us, guard_us, cc_sense,
        output frs_tx_out, frs_busy, frs_done, frs_rej, frs_abort, frs_err
    );
endinterface

// File: rtl/apb_ucpd_frs_tx.sv
// FRS transmitter: drives the CC pull-down for max(pulse_us,1) us, then a guard_us gap; UCPD_FRS_CHK_EN adds a CC line check.
// Latency: accepted request drives frs_tx_out from the next cycle; status pulses are registered (one cycle after the event).
// Backpressure: none; requests arriving while busy, disabled or with clk_freq==0 are dropped and flagged on frs_rej.
module apb_ucpd_frs_tx #(
    parameter int US_W   = 10,
    parameter int FREQ_W = 6
) (
    input  logic               ic_clk,
    input  logic               ic_rst_n,
    apb_ucpd_frs_tx_if.slave   bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] GUARD = 2'd2;

    localparam logic [FREQ_W-1:0] F_ONE = {{(FREQ_W-1){1'b0}}, 1'b1};
    localparam logic [US_W-1:0]   U_ONE = {{(US_W-1){1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [FREQ_W-1:0] freq_q;
    logic [FREQ_W-1:0] pre_cnt;
    logic [US_W-1:0]   pulse_q;
    logic [US_W-1:0]   guard_q;
    logic [US_W-1:0]   us_cnt;
    logic              out_q;
    logic              done_q;
    logic              rej_q;
    logic              abort_q;

    logic              running;
    logic              tick;
    logic              accept;
    logic              abort_now;
    logic              drive_end;
    logic              guard_end;
    logic              done_now;
    logic [US_W-1:0]   drive_last;

    assign running    = (state == DRIVE) || (state == GUARD);
    assign tick       = running && (pre_cnt == (freq_q - F_ONE));
    assign accept     = (state == IDLE) && bus.frs_en && bus.frs_tx_req && (bus.clk_freq != '0);
    assign abort_now  = running && !bus.frs_en;

    // A programmed pulse of 0 us behaves as 1 us.
    assign drive_last = (pulse_q == '0) ? '0 : (pulse_q - U_ONE);
    assign drive_end  = (state == DRIVE) && tick && (us_cnt == drive_last);
    assign guard_end  = (state == GUARD) && tick && (us_cnt == (guard_q - U_ONE));
    assign done_now   = !abort_now && ((drive_end && (guard_q == '0)) || guard_end);

    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            state   <= IDLE;
            freq_q  <= '0;
            pulse_q <= '0;
            guard_q <= '0;
            pre_cnt <= '0;
            us_cnt  <= '0;
            out_q   <= 1'b0;
        end else if (abort_now) begin
            state   <= IDLE;
            pre_cnt <= '0;
            us_cnt  <= '0;
            out_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pre_cnt <= '0;
                    us_cnt  <= '0;
                    out_q   <= 1'b0;
                    if (accept) begin
                        freq_q  <= bus.clk_freq;
                        pulse_q <= bus.pulse_us;
                        guard_q <= bus.guard_us;
                        state   <= DRIVE;
                        out_q   <= 1'b1;
                    end
                end
                DRIVE: begin
                    pre_cnt <= tick ? '0 : (pre_cnt + F_ONE);
                    if (drive_end) begin
                        us_cnt <= '0;
                        out_q  <= 1'b0;
                        state  <= (guard_q == '0) ? IDLE : GUARD;
                    end else if (tick) begin
                        us_cnt <= us_cnt + U_ONE;
                    end
                end
                GUARD: begin
                    pre_cnt <= tick ? '0 : (pre_cnt + F_ONE);
                    out_q   <= 1'b0;
                    if (guard_end) begin
                        us_cnt <= '0;
                        state  <= IDLE;
                    end else if (tick) begin
                        us_cnt <= us_cnt + U_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pre_cnt <= '0;
                    us_cnt  <= '0;
                    out_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            done_q  <= 1'b0;
            rej_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            done_q  <= done_now;
            rej_q   <= bus.frs_tx_req && !accept;
            abort_q <= abort_now;
        end
    end

`ifdef UCPD_FRS_CHK_EN
    logic mis_flag;
    logic mis_next;
    logic err_q;

    // The final drive tick is folded in combinationally so it can still flag the completing sequence.
    assign mis_next = mis_flag || ((state == DRIVE) && tick && bus.cc_sense);

    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            mis_flag <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            mis_flag <= (accept || abort_now) ? 1'b0 : mis_next;
            err_q    <= done_now && mis_next;
        end
    end

    assign bus.frs_err = err_q;
`else
    logic unused_cc_sense;
    assign unused_cc_sense = bus.cc_sense;
    assign bus.frs_err     = 1'b0;
`endif

    assign bus.frs_tx_out = out_q;
    assign bus.frs_busy   = (state != IDLE);
    assign bus.frs_done   = done_q;
    assign bus.frs_rej    = rej_q;
    assign bus.frs_abort  = abort_q;

endmodule

// File: tb/tb_apb_ucpd_frs_tx.sv
// Directed bench for apb_ucpd_frs_tx: pulse/guard timing, rejects, abort, async reset and (with UCPD_FRS_CHK_EN) the line check.
module tb_apb_ucpd_frs_tx;

    logic ic_clk;
    logic ic_rst_n;
    int   n_cmp;
    int   n_err;

    apb_ucpd_frs_tx_if bus ();

    apb_ucpd_frs_tx dut (
        .ic_clk   (ic_clk),
        .ic_rst_n (ic_rst_n),
        .bus      (bus)
    );

    initial ic_clk = 1'b0;
    always #5 ic_clk = ~ic_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Issues a one-cycle request at the current falling edge, then counts high cycles until frs_done.
    task automatic run_seq(input logic [5:0] f, input logic [9:0] p, input logic [9:0] g,
                           input int bound, output int hi, output int done_at,
                           output logic busy_d, output logic err_d);
        bus.clk_freq   = f;
        bus.pulse_us   = p;
        bus.guard_us   = g;
        bus.frs_tx_req = 1'b1;
        @(negedge ic_clk);
        bus.frs_tx_req = 1'b0;
        hi      = 0;
        done_at = -1;
        busy_d  = 1'b1;
        err_d   = 1'b1;
        for (int k = 1; k <= bound; k++) begin
            if (bus.frs_tx_out) hi++;
            if (bus.frs_done) begin
                done_at = k;
                busy_d  = bus.frs_busy;
                err_d   = bus.frs_err;
                break;
            end
            @(negedge ic_clk);
        end
    endtask

    int   hi;
    int   done_at;
    int   done_cnt;
    logic busy_d;
    logic err_d;

    initial begin
        n_cmp = 0;
        n_err = 0;
        ic_rst_n       = 1'b0;
        bus.clk_freq   = '0;
        bus.frs_en     = 1'b1;
        bus.frs_tx_req = 1'b0;
        bus.pulse_us   = '0;
        bus.guard_us   = '0;
        bus.cc_sense   = 1'b0;
        repeat (3) @(negedge ic_clk);
        check("rst_out",   bus.frs_tx_out, 0);
        check("rst_busy",  bus.frs_busy,   0);
        check("rst_flags", {bus.frs_done, bus.frs_rej, bus.frs_abort, bus.frs_err}, 0);
        ic_rst_n = 1'b1;
        repeat (2) @(negedge ic_clk);

        // 48 MHz, 100 us pulse, 20 us guard
        run_seq(6'd48, 10'd100, 10'd20, 7000, hi, done_at, busy_d, err_d);
        check("p48_hi",    hi, 4800);
        check("p48_done",  done_at, 5761);
        check("p48_busy",  busy_d, 0);
        check("p48_err",   err_d, 0);
        @(negedge ic_clk);
        check("p48_done1", bus.frs_done, 0);

        // 8 MHz, pulse 0 treated as 1 us, no guard
        run_seq(6'd8, 10'd0, 10'd0, 100, hi, done_at, busy_d, err_d);
        check("p8_hi",   hi, 8);
        check("p8_done", done_at, 9);
        check("p8_busy", busy_d, 0);
        @(negedge ic_clk);

        // Second request mid-DRIVE must be rejected and must not alter the pulse
        bus.clk_freq = 6'd48; bus.pulse_us = 10'd100; bus.guard_us = 10'd0;
        bus.frs_tx_req = 1'b1;
        @(negedge ic_clk);
        bus.frs_tx_req = 1'b0;
        hi = 0; done_at = -1;
        for (int k = 1; k <= 6000; k++) begin
            if (bus.frs_tx_out) hi++;
            if (k == 1) check("rej_first", bus.frs_rej, 0);
            if (k == 500) begin bus.frs_tx_req = 1'b1; bus.pulse_us = 10'd5; bus.clk_freq = 6'd2; end
            if (k == 501) begin bus.frs_tx_req = 1'b0; check("rej_busy", bus.frs_rej, 1); end
            if (k == 502) check("rej_pulse1", bus.frs_rej, 0);
            if (bus.frs_done) begin done_at = k; break; end
            @(negedge ic_clk);
        end
        check("rej_hi",   hi, 4800);
        check("rej_done", done_at, 4801);
        @(negedge ic_clk);

        // clk_freq == 0 request
        bus.clk_freq = 6'd0; bus.pulse_us = 10'd3; bus.frs_tx_req = 1'b1;
        @(negedge ic_clk);
        bus.frs_tx_req = 1'b0;
        check("rej_f0",      bus.frs_rej, 1);
        check("rej_f0_busy", bus.frs_busy, 0);
        // request while disabled
        bus.clk_freq = 6'd8; bus.frs_en = 1'b0; bus.frs_tx_req = 1'b1;
        @(negedge ic_clk);
        bus.frs_tx_req = 1'b0;
        check("rej_dis",      bus.frs_rej, 1);
        check("rej_dis_busy", bus.frs_busy, 0);
        bus.frs_en = 1'b1;
        @(negedge ic_clk);

        // Abort by dropping frs_en at drive cycle 1000
        bus.clk_freq = 6'd48; bus.pulse_us = 10'd100; bus.guard_us = 10'd20;
        bus.frs_tx_req = 1'b1;
        @(negedge ic_clk);
        bus.frs_tx_req = 1'b0;
        repeat (999) @(negedge ic_clk);
        check("abt_pre_out", bus.frs_tx_out, 1);
        bus.frs_en = 1'b0;
        @(negedge ic_clk);
        check("abt_out",   bus.frs_tx_out, 0);
        check("abt_flag",  bus.frs_abort, 1);
        check("abt_busy",  bus.frs_busy, 0);
        check("abt_done0", bus.frs_done, 0);
        done_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge ic_clk);
            if (bus.frs_done) done_cnt++;
        end
        check("abt_nodone", done_cnt, 0);
        bus.frs_en = 1'b1;
        run_seq(6'd48, 10'd100, 10'd20, 7000, hi, done_at, busy_d, err_d);
        check("abt_re_hi",   hi, 4800);
        check("abt_re_done", done_at, 5761);
        @(negedge ic_clk);

        // Asynchronous reset mid-DRIVE
        bus.clk_freq = 6'd8; bus.pulse_us = 10'd100; bus.guard_us = 10'd0;
        bus.frs_tx_req = 1'b1;
        @(negedge ic_clk);
        bus.frs_tx_req = 1'b0;
        repeat (200) @(negedge ic_clk);
        ic_rst_n = 1'b0;
        #1;
        check("arst_out",  bus.frs_tx_out, 0);
        check("arst_busy", bus.frs_busy, 0);
        @(negedge ic_clk);
        ic_rst_n = 1'b1;
        @(negedge ic_clk);
        run_seq(6'd8, 10'd3, 10'd2, 200, hi, done_at, busy_d, err_d);
        check("arst_hi",   hi, 24);
        check("arst_done", done_at, 41);
        @(negedge ic_clk);

`ifdef UCPD_FRS_CHK_EN
        // cc_sense high across the first us tick (drive cycle 4 at 4 MHz)
        bus.clk_freq = 6'd4; bus.pulse_us = 10'd3; bus.guard_us = 10'd0;
        bus.frs_tx_req = 1'b1;
        @(negedge ic_clk);
        bus.frs_tx_req = 1'b0;
        done_at = -1; err_d = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (k == 4) bus.cc_sense = 1'b1;
            if (k == 5) bus.cc_sense = 1'b0;
            if (bus.frs_done) begin done_at = k; err_d = bus.frs_err; break; end
            @(negedge ic_clk);
        end
        check("chk_done", done_at, 13);
        check("chk_err",  err_d, 1);
        @(negedge ic_clk);
        check("chk_err1", bus.frs_err, 0);
        run_seq(6'd4, 10'd3, 10'd0, 100, hi, done_at, busy_d, err_d);
        check("chk_clean_err", err_d, 0);
        @(negedge ic_clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
